// File: rtl/full_adder.sv
// Registered full adder: a ripple chain of one-bit slices feeding the output registers.
// WIDTH=1 gives the classic 1-bit full adder; wider instances chain one slice per bit.

module fa_slice (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             out_valid,
    output logic             ovf
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        fa_slice u_slice (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    // Result registers only load on valid inputs; out_valid is a one-cycle strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s         <= '0;
            co        <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s   <= sum;
                co  <= carry[WIDTH];
                ovf <= carry[WIDTH] ^ carry[WIDTH-1];
            end
        end
    end
endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: WIDTH=1 and WIDTH=8 instances against an arithmetic model.

module tb_full_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       c;
    logic       a1, b1;
    logic [7:0] a8, b8;

    logic       s1, co1, ov1, ovf1;
    logic [7:0] s8;
    logic       co8, ov8, ovf8;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1), .c(c),
        .s(s1), .co(co1), .out_valid(ov1), .ovf(ovf1)
    );

    full_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8), .c(c),
        .s(s8), .co(co8), .out_valid(ov8), .ovf(ovf8)
    );

    typedef struct {
        logic a, b, c;
        logic co, s;
    } vec1_t;

    typedef struct {
        logic [7:0] a, b;
        logic       c;
        logic [7:0] s;
        logic       co, ovf;
    } vec8_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer sum; signed overflow from the two's-complement range.
    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic ci);
        int u, r;
        logic o;
        u = int'(a) + int'(b) + int'(ci);
        r = int'($signed(a)) + int'($signed(b)) + int'(ci);
        o = (r > 127) || (r < -128);
        return {o, u[8:0]};
    endfunction

    function automatic logic [2:0] model1(input logic a, input logic b, input logic ci);
        int u, r;
        logic o;
        u = int'(a) + int'(b) + int'(ci);
        r = -int'(a) - int'(b) + int'(ci);
        o = (r > 0) || (r < -1);
        return {o, u[1:0]};
    endfunction

    vec1_t tt1[8];
    vec8_t tt8[3];

    initial begin
        logic [9:0] e8;
        logic [2:0] e1;

        tt1[0] = '{0,0,0, 0,0}; tt1[1] = '{0,0,1, 0,1};
        tt1[2] = '{0,1,0, 0,1}; tt1[3] = '{0,1,1, 1,0};
        tt1[4] = '{1,0,0, 0,1}; tt1[5] = '{1,0,1, 1,0};
        tt1[6] = '{1,1,0, 1,0}; tt1[7] = '{1,1,1, 1,1};
        tt8[0] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        tt8[1] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        tt8[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; c = 1'b0;
        a1 = 1'b0; b1 = 1'b0; a8 = '0; b8 = '0;
        step();
        step();
        check("reset_w1", {s1, co1, ovf1, ov1}, 4'b0);
        check("reset_w8", {s8, co8, ovf8, ov8}, 11'b0);
        rst = 1'b0;

        // Exhaustive 1-bit truth table, back to back.
        for (int i = 0; i < 8; i++) begin
            a1 = tt1[i].a; b1 = tt1[i].b; c = tt1[i].c; in_valid = 1'b1;
            step();
            e1 = model1(tt1[i].a, tt1[i].b, tt1[i].c);
            check($sformatf("tt1_%0d_cos", i), {co1, s1}, {tt1[i].co, tt1[i].s});
            check($sformatf("tt1_%0d_ovf", i), ovf1, e1[2]);
            check($sformatf("tt1_%0d_vld", i), ov1, 1'b1);
        end

        // Hold: invalid cycle must keep previous result.
        a1 = 1'b1; b1 = 1'b1; c = 1'b1; in_valid = 1'b1;
        step();
        a1 = 1'b0; b1 = 1'b0; c = 1'b0; in_valid = 1'b0;
        step();
        check("hold_cos", {co1, s1}, 2'b11);
        check("hold_vld", ov1, 1'b0);

        // Asynchronous reset mid-cycle clears outputs before the next edge.
        #2 rst = 1'b1;
        #1;
        check("async_rst_w1", {s1, co1, ovf1, ov1}, 4'b0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_idle", {s1, co1, ovf1, ov1}, 4'b0);

        // 8-bit carry-chain corners.
        for (int i = 0; i < 3; i++) begin
            a8 = tt8[i].a; b8 = tt8[i].b; c = tt8[i].c; in_valid = 1'b1;
            step();
            check($sformatf("tt8_%0d", i), {co8, s8, ovf8, ov8},
                  {tt8[i].co, tt8[i].s, tt8[i].ovf, 1'b1});
        end

        // Random back-to-back throughput on both widths.
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            logic       rc, r1a, r1b;
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            r1a = 1'($urandom); r1b = 1'($urandom);
            a8 = ra; b8 = rb; c = rc; a1 = r1a; b1 = r1b; in_valid = 1'b1;
            step();
            e8 = model8(ra, rb, rc);
            e1 = model1(r1a, r1b, rc);
            check($sformatf("rnd8_%0d", i), {ovf8, co8, s8, ov8}, {e8, 1'b1});
            check($sformatf("rnd1_%0d", i), {ovf1, co1, s1, ov1}, {e1, 1'b1});
        end

        in_valid = 1'b0;
        step();
        check("final_idle_vld", {ov1, ov8}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
Registered one-bit-slice-extensible full adder. It computes s = a + b + c and registers the sum and carry-out on the rising clock edge. With the default WIDTH=1 it is the classic 1-bit full adder (three 1-bit inputs, sum and carry outputs). It serves as the arithmetic leaf cell for datapath adders and as a lab reference cell. Wider instances chain full-adder slices as an internal ripple-carry structure.

Parameters:
WIDTH, 1, operand width in bits (legal range 1..64); each bit is one full-adder slice.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  qualifies a, b and c in the current cycle.
a  input  WIDTH  addend A (unsigned).
b  input  WIDTH  addend B (unsigned).
c  input  1  carry-in.
s  output  WIDTH  registered sum, a+b+c modulo 2^WIDTH.
co  output  1  registered carry-out, bit WIDTH of a+b+c.
out_valid  output  1  high for one cycle when s/co hold a new result.
ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: while rst=1, s=0, co=0, ovf=0 and out_valid=0 immediately, independent of clk. Reset asserted mid-operation discards any result in flight. The first capture after rst deasserts happens on the next rising clk edge.
- Slice function: for each bit i:
  - sum_i = a[i] ^ b[i] ^ carry_i
  - carry_(i+1) = (a[i]&b[i]) | (a[i]&carry_i) | (b[i]&carry_i)
  - carry_0 = c
  - co = carry_WIDTH
- Concatenation {co,s} equals a+b+c exactly; it never saturates and wraps modulo 2^(WIDTH+1).
- ovf = carry_WIDTH ^ carry_(WIDTH-1).
  - For WIDTH=1, carry_0 = c, so ovf = co ^ c.
- Latency: exactly 1 cycle. Inputs sampled at rising edge N with in_valid=1 appear on s/co/ovf after edge N, and out_valid=1 for that cycle.
- in_valid=0 at an edge: s, co and ovf hold their previous values, and out_valid=0.
- Back-to-back valid inputs give one result per cycle; there is no backpressure and no stall.
- Inputs with X are not defined. Outputs are never X after reset.
- The adder logic is purely combinational between the input pins and the output registers. There is no other state and no other state machine.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with prior s=1, co=1 -> s=0, co=0, ovf=0, out_valid=0 before the next edge. They stay 0 until the first valid edge after release.
- WIDTH=1 exhaustive truth table, one vector per cycle with in_valid=1. (a,b,c) = 000,001,010,011,100,101,110,111 -> (co,s) = 00,01,01,10,01,10,10,11, each appearing one cycle after application with out_valid=1.
- Hold: apply a=1, b=1, c=1 valid, then change inputs to 000 with in_valid=0 -> s=1, co=1 persist and out_valid=0.
- WIDTH=8 carry chain: a=8'hFF, b=8'h00, c=1 -> s=8'h00, co=1, ovf=0. Then a=8'h7F, b=8'h00, c=1 -> s=8'h80, co=0, ovf=1.
- WIDTH=8 maximum: a=8'hFF, b=8'hFF, c=1 -> s=8'hFF, co=1, ovf=0.
- Random throughput: 1000 back-to-back valid random vectors at WIDTH=8 -> each {co,s} equals a+b+c of the vector from the previous cycle, with out_valid=1 every cycle.
